gshare_pht_ctrl: RTL and testbench
==================================

GSHARE_PHT_CTRL -- requirements
Module: gshare_pht_ctrl

Interface
REQ-001 Parameters: none; fixed PHT of 128 x 2-bit entries, 7-bit index and history, training FIFO depth 4.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 areset  in  1  reset, asynchronous, active-high.
REQ-004 pred_valid  in  1  prediction request; accepted when pred_valid && pred_ready.
REQ-005 pred_pc  in  7  branch PC of the prediction request.
REQ-006 pred_ready  out  1  controller can accept a prediction this cycle.
REQ-007 pred_resp_valid  out  1  prediction result valid, one cycle after acceptance.
REQ-008 pred_taken  out  1  predicted direction (PHT entry bit 1).
REQ-009 pred_history  out  7  global history used to form the prediction index.
REQ-010 trn_valid, trn_taken, trn_mispredicted  in  1 each  training request and its resolved outcome.
REQ-011 trn_history, trn_pc  in  7 each  history and PC of the branch being trained.
REQ-012 trn_ready  out  1  training FIFO can accept an entry.
REQ-013 mem_en, mem_we  out  1 each  single-port PHT RAM enable / write enable.
REQ-014 mem_addr  out  7; mem_wdata  out  2; mem_rdata  in  2, valid the cycle after a read is issued.
REQ-015 fifo_count  out  3  occupancy of the training FIFO, 0..4.

Function
REQ-016 States SHALL be INIT, IDLE, RD and WR.
- INIT: fill the PHT.
- IDLE: no training in progress.
- RD: training read issued or pending.
- WR: training write pending.
REQ-017 In INIT, one write per cycle: addr 0..127 in order, wdata 2'b01 (weakly not-taken), mem_we=1. Move to IDLE after address 127 is written. pred_ready and trn_ready SHALL be 0 throughout INIT.
REQ-018 Port priority per cycle: INIT write > accepted prediction read > training RD/WR. At most one RAM access per cycle.
REQ-019 pred_ready = (state!=INIT) && !resp_pending && (fifo_count<4).
- resp_pending is set the cycle after an acceptance.
- A full FIFO thus yields the port to training, so training cannot starve.
REQ-020 Prediction accept in cycle T: mem_en=1, mem_we=0, mem_addr = ghr ^ pred_pc.
- In T+1: pred_resp_valid=1, pred_taken=mem_rdata[1], pred_history = ghr value used in T.
- At the end of T+1: ghr <= {ghr[5:0], pred_taken}, unless REQ-022 applies.
REQ-021 trn_ready = (state!=INIT) && (fifo_count<4).
- A push stores {taken, history^pc}.
- Push and pop in the same cycle are allowed; fifo_count is then unchanged.
REQ-022 Accepting a training entry with trn_mispredicted=1 SHALL set ghr <= {trn_history[5:0], trn_taken} at that edge. This overrides a simultaneous speculative update from REQ-020.
REQ-023 IDLE -> RD when fifo_count>0.
REQ-024 RD: when the port is free, issue a read of the head entry's index, then go to WR. Otherwise stay in RD.
REQ-025 First WR cycle: latch mem_rdata as cnt.
- Write to the same index when the port is free: cnt+1 saturating at 3 if taken, cnt-1 saturating at 0 if not taken.
- Hold in WR with the latched cnt while the port is busy.
REQ-026 Pop the FIFO on the write cycle. Next state SHALL be RD if entries remain after the pop, else IDLE.
REQ-027 Training entries SHALL be applied strictly in FIFO order, one read-modify-write at a time, so repeated updates to one index accumulate. A prediction read during an outstanding update to the same index returns the pre-update value; this is accepted behaviour.

Reset
REQ-028 areset SHALL immediately drive the following, and INIT restarts from address 0 on release:
- state=INIT, ghr=0, resp_pending=0, FIFO empty (fifo_count=0), training state cleared.
- pred_resp_valid=0, pred_taken=0, pred_history=0.
- pred_ready=0, trn_ready=0.
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset mid-operation SHALL discard all queued training entries and any pending response, then rerun the full INIT.

Verification
REQ-030 Release reset -> 128 consecutive writes, addr 0..127, wdata 01; pred_ready=1 on the cycle after the addr-127 write.
REQ-031 ghr=0, predict pc=5, mem_rdata=01 -> read addr 5; next cycle pred_resp_valid=1, taken=0, history=0; ghr stays 0 and pred_ready=0 for that cycle.
REQ-032 Train pc=3, history=1, taken=1, mem_rdata=01 -> read addr 2; next cycle write addr 2, wdata 10; fifo_count 1->0.
REQ-033 Saturation: taken with rdata 11 -> write 11; not-taken with rdata 00 -> write 00.
REQ-034 Four trains with continuous pred_valid -> fifo_count reaches 4, pred_ready=0, trn_ready=0; training drains; pred_ready returns once fifo_count<4.
REQ-035 Mispredicted train (history=7'h15, taken=1) accepted in a pred_resp_valid cycle with taken=0 -> ghr=7'h2B next cycle.

Source files
------------

// File: rtl/gshare_pht_ctrl_if.sv
// Prediction, training and PHT RAM signals of the gshare controller.
interface gshare_pht_ctrl_if;
  logic       pred_valid;
  logic [6:0] pred_pc;
  logic       pred_ready;
  logic       pred_resp_valid;
  logic       pred_taken;
  logic [6:0] pred_history;
  logic       trn_valid;
  logic       trn_taken;
  logic       trn_mispredicted;
  logic [6:0] trn_history;
  logic [6:0] trn_pc;
  logic       trn_ready;
  logic       mem_en;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;
  logic [2:0] fifo_count;

  modport slave (
    input  pred_valid, pred_pc, trn_valid, trn_taken, trn_mispredicted,
           trn_history, trn_pc, mem_rdata,
    output pred_ready, pred_resp_valid, pred_taken, pred_history, trn_ready,
           mem_en, mem_we, mem_addr, mem_wdata, fifo_count
  );

  modport master (
    output pred_valid, pred_pc, trn_valid, trn_taken, trn_mispredicted,
           trn_history, trn_pc, mem_rdata,
    input  pred_ready, pred_resp_valid, pred_taken, pred_history, trn_ready,
           mem_en, mem_we, mem_addr, mem_wdata, fifo_count
  );
endinterface

// File: rtl/gshare_pht_ctrl.sv
// Gshare predictor controller: 128x2-bit PHT over a single-port RAM, prediction
// reads with priority, training read-modify-writes drained in order from a 4-deep FIFO.
//
// state | meaning
// INIT  | fill the PHT with weakly-not-taken, one entry per cycle
// IDLE  | no training in progress
// RD    | training read issued or pending
// WR    | training write pending
module gshare_pht_ctrl (
  input  logic             clk,
  input  logic             areset,
  gshare_pht_ctrl_if.slave bus
);

  typedef enum logic [1:0] {INIT, IDLE, RD, WR} state_t;

  state_t     state, state_nxt;
  logic       init_armed;
  logic [6:0] init_addr;
  logic [6:0] ghr;
  logic [6:0] hist_q;
  logic       resp_pending;
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count, count_nxt;
  logic [1:0] cnt_q;
  logic       cnt_valid;

  logic       pred_acc;
  logic       push;
  logic       pop;
  logic [7:0] head;
  logic [1:0] cnt_cur;
  logic [1:0] cnt_upd;

  always_comb begin
    bus.pred_ready      = (state != INIT) && !resp_pending && (count < 3'd4);
    bus.trn_ready       = (state != INIT) && (count < 3'd4);
    bus.pred_resp_valid = resp_pending;
    bus.pred_taken      = resp_pending & bus.mem_rdata[1];
    bus.pred_history    = hist_q;
    bus.fifo_count      = count;
    pred_acc            = bus.pred_valid && bus.pred_ready;
    push                = bus.trn_valid && bus.trn_ready;
    head                = fifo_mem[rd_ptr];
    // The RAM data is only valid on the first WR cycle; later cycles use the latched copy.
    cnt_cur             = cnt_valid ? cnt_q : bus.mem_rdata;
    if (head[7]) cnt_upd = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'd1;
    else         cnt_upd = (cnt_cur == 2'b00) ? 2'b00 : cnt_cur - 2'd1;
  end

  always_comb begin
    state_nxt     = state;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 7'd0;
    bus.mem_wdata = 2'b00;
    pop           = 1'b0;
    if (pred_acc) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = ghr ^ bus.pred_pc;
    end
    case (state)
      INIT: begin
        if (init_armed) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = init_addr;
          bus.mem_wdata = 2'b01;
          if (init_addr == 7'd127) state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (count != 3'd0) state_nxt = RD;
      end
      RD: begin
        if (!pred_acc) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = head[6:0];
          state_nxt    = WR;
        end
      end
      WR: begin
        if (!pred_acc) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = head[6:0];
          bus.mem_wdata = cnt_upd;
          pop           = 1'b1;
        end
      end
      default: state_nxt = INIT;
    endcase
    count_nxt = count + {2'b00, push} - {2'b00, pop};
    if (pop) state_nxt = (count_nxt != 3'd0) ? RD : IDLE;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= INIT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      init_armed   <= 1'b0;
      init_addr    <= 7'd0;
      ghr          <= 7'd0;
      hist_q       <= 7'd0;
      resp_pending <= 1'b0;
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      count        <= 3'd0;
      cnt_q        <= 2'b00;
      cnt_valid    <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'd0;
    end else begin
      init_armed   <= 1'b1;
      if (state == INIT && init_armed) init_addr <= init_addr + 7'd1;
      resp_pending <= pred_acc;
      if (pred_acc) hist_q <= ghr;
      // A resolved mispredict restores the architectural history over the speculative shift.
      if (push && bus.trn_mispredicted) ghr <= {bus.trn_history[5:0], bus.trn_taken};
      else if (resp_pending)            ghr <= {ghr[5:0], bus.mem_rdata[1]};
      if (push) begin
        fifo_mem[wr_ptr] <= {bus.trn_taken, bus.trn_history ^ bus.trn_pc};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count_nxt;
      if (pop) cnt_valid <= 1'b0;
      else if (state == WR && !cnt_valid) begin
        cnt_q     <= bus.mem_rdata;
        cnt_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// Self-checking bench for gshare_pht_ctrl: behavioural PHT RAM, reference PHT/history
// model and scoreboard queues for prediction responses and training writes.
module tb_gshare_pht_ctrl;
  logic clk = 1'b0;
  logic areset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  gshare_pht_ctrl_if bus ();
  gshare_pht_ctrl dut (.clk(clk), .areset(areset), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency; poke lets tests preload entries.
  logic [1:0] ram [128];
  logic [1:0] rdata_q = 2'b00;
  logic       poke_en = 1'b0;
  logic [6:0] poke_addr = 7'd0;
  logic [1:0] poke_val = 2'b00;
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_val;
    else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            rdata_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_q;

  // Reference model and scoreboard, updated at the falling edge for the coming rising edge.
  logic       mon_on = 1'b0;
  logic [1:0] ref_pht [128];
  logic [6:0] ghr_ref;
  logic [7:0] rq [$];
  logic [8:0] wq [$];
  logic [7:0] m_e;
  logic [8:0] m_w;
  logic [6:0] m_idx;
  logic [1:0] m_c;
  logic       resp_now;

  always @(negedge clk) begin
    if (!mon_on) begin
      for (int i = 0; i < 128; i++) ref_pht[i] = 2'b01;
      ghr_ref = 7'd0;
      rq.delete();
      wq.delete();
    end else begin
      resp_now = 1'b0;
      if (bus.pred_resp_valid) begin
        n_vec++;
        if (rq.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: response with no prediction outstanding");
        end else begin
          m_e = rq.pop_front();
          resp_now = 1'b1;
          if ({bus.pred_taken, bus.pred_history} !== m_e) begin
            n_err++;
            $display("FAIL pred_resp: taken=%0b hist=%h, expected taken=%0b hist=%h",
                     bus.pred_taken, bus.pred_history, m_e[7], m_e[6:0]);
          end
        end
      end
      if (bus.pred_valid && bus.pred_ready) begin
        m_idx = ghr_ref ^ bus.pred_pc;
        n_vec++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== m_idx) begin
          n_err++;
          $display("FAIL pred_read: en=%0b we=%0b addr=%h, expected read of %h",
                   bus.mem_en, bus.mem_we, bus.mem_addr, m_idx);
        end
        rq.push_back({ref_pht[m_idx][1], ghr_ref});
      end
      if (bus.mem_en && bus.mem_we) begin
        n_vec++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: addr=%h data=%b with no training queued",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          m_w = wq.pop_front();
          if ({bus.mem_addr, bus.mem_wdata} !== m_w) begin
            n_err++;
            $display("FAIL trn_write: addr=%h data=%b, expected addr=%h data=%b",
                     bus.mem_addr, bus.mem_wdata, m_w[8:2], m_w[1:0]);
          end
        end
      end
      if (poke_en) ref_pht[poke_addr] = poke_val;
      if (bus.trn_valid && bus.trn_ready) begin
        m_idx = bus.trn_history ^ bus.trn_pc;
        m_c   = ref_pht[m_idx];
        if (bus.trn_taken) m_c = (m_c == 2'b11) ? 2'b11 : m_c + 2'd1;
        else               m_c = (m_c == 2'b00) ? 2'b00 : m_c - 2'd1;
        ref_pht[m_idx] = m_c;
        wq.push_back({m_idx, m_c});
      end
      if (bus.trn_valid && bus.trn_ready && bus.trn_mispredicted)
        ghr_ref = {bus.trn_history[5:0], bus.trn_taken};
      else if (resp_now)
        ghr_ref = {ghr_ref[5:0], m_e[7]};
    end
  end

  task automatic poke(input logic [6:0] a, input logic [1:0] v);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic drive_pred(input logic [6:0] pc);
    bit ok = 0;
    @(posedge clk); #1;
    bus.pred_valid = 1'b1; bus.pred_pc = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pred_ready) begin ok = 1; break; end
    end
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL pred_accept_timeout: pc=%h", pc); end
    @(posedge clk); #1;
    bus.pred_valid = 1'b0;
  endtask

  task automatic drive_trn(input logic [6:0] pc, input logic [6:0] hist,
                           input logic tk, input logic mis);
    @(posedge clk); #1;
    bus.trn_valid = 1'b1; bus.trn_pc = pc; bus.trn_history = hist;
    bus.trn_taken = tk; bus.trn_mispredicted = mis;
    @(negedge clk);
    n_vec++;
    if (bus.trn_ready !== 1'b1) begin n_err++; $display("FAIL trn_accept: ready=%0b expected 1", bus.trn_ready); end
    @(posedge clk); #1;
    bus.trn_valid = 1'b0; bus.trn_mispredicted = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_vec++;
    if ({bus.pred_ready, bus.trn_ready, bus.pred_resp_valid, bus.pred_taken, bus.pred_history,
         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.fifo_count} !== 24'd0) begin
      n_err++;
      $display("FAIL reset_outputs: en=%0b we=%0b addr=%h cnt=%0d prdy=%0b trdy=%0b, expected all 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.fifo_count, bus.pred_ready, bus.trn_ready);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL reset_no_init: mem_en=%0b expected 0", bus.mem_en); end
  endtask

  task automatic test_init;
    int k = 0;
    int bad_rdy = 0;
    int gaps = 0;
    mon_on = 1'b0;
    @(negedge clk);
    areset = 1'b0;
    for (int cyc = 0; cyc < 300 && k < 128; cyc++) begin
      @(negedge clk);
      if (bus.pred_ready || bus.trn_ready) bad_rdy++;
      if (bus.mem_en) begin
        n_vec++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== k[6:0] || bus.mem_wdata !== 2'b01) begin
          n_err++;
          $display("FAIL init_write: we=%0b addr=%h data=%b, expected we=1 addr=%h data=01",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata, k[6:0]);
        end
        k++;
      end else if (k > 0) gaps++;
    end
    n_vec++;
    if (k !== 128 || gaps !== 0) begin
      n_err++;
      $display("FAIL init_count: writes=%0d gaps=%0d, expected 128 consecutive", k, gaps);
    end
    n_vec++;
    if (bad_rdy !== 0) begin n_err++; $display("FAIL init_ready: ready seen %0d cycles, expected 0", bad_rdy); end
    @(negedge clk);
    n_vec++;
    if ({bus.pred_ready, bus.trn_ready, bus.mem_en} !== 3'b110) begin
      n_err++;
      $display("FAIL init_done: prdy=%0b trdy=%0b en=%0b, expected 1 1 0",
               bus.pred_ready, bus.trn_ready, bus.mem_en);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_predict;
    @(posedge clk); #1;
    bus.pred_valid = 1'b1; bus.pred_pc = 7'd5;
    @(negedge clk);
    n_vec++;
    if ({bus.pred_ready, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b110, 7'd5}) begin
      n_err++;
      $display("FAIL pred_issue: rdy=%0b en=%0b we=%0b addr=%h, expected 1 1 0 05",
               bus.pred_ready, bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    @(posedge clk); #1;
    bus.pred_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.pred_resp_valid, bus.pred_taken, bus.pred_history, bus.pred_ready} !== {2'b10, 7'h00, 1'b0}) begin
      n_err++;
      $display("FAIL pred_first_resp: v=%0b t=%0b h=%h rdy=%0b, expected 1 0 00 0",
               bus.pred_resp_valid, bus.pred_taken, bus.pred_history, bus.pred_ready);
    end
    poke(7'd0, 2'b10);
    drive_pred(7'd0);
    @(negedge clk);
    n_vec++;
    if ({bus.pred_resp_valid, bus.pred_taken, bus.pred_history} !== {2'b11, 7'h00}) begin
      n_err++;
      $display("FAIL pred_taken_resp: v=%0b t=%0b h=%h, expected 1 1 00",
               bus.pred_resp_valid, bus.pred_taken, bus.pred_history);
    end
    drive_pred(7'h7F);
    @(negedge clk);
    n_vec++;
    if ({bus.pred_resp_valid, bus.pred_taken, bus.pred_history} !== {2'b10, 7'h01}) begin
      n_err++;
      $display("FAIL pred_shift_resp: v=%0b t=%0b h=%h, expected 1 0 01",
               bus.pred_resp_valid, bus.pred_taken, bus.pred_history);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_train;
    bit found = 0;
    drive_trn(7'd3, 7'd1, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL trn_count_up: count=%0d expected 1", bus.fifo_count); end
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_en) begin found = 1; break; end
      @(negedge clk);
    end
    n_vec++;
    if (found !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 7'd2) begin
      n_err++;
      $display("FAIL trn_read: found=%0b we=%0b addr=%h, expected read of 02", found, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 7'd2, 2'b10}) begin
      n_err++;
      $display("FAIL trn_rmw_write: en=%0b we=%0b addr=%h data=%b, expected 1 1 02 10",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    n_vec++;
    if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL trn_count_down: count=%0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_saturation;
    logic [6:0] idx;
    logic       tk;
    logic [1:0] pre;
    logic [1:0] exp_w;
    bit         found;
    for (int s = 0; s < 2; s++) begin
      idx   = (s == 0) ? 7'd10 : 7'd20;
      tk    = (s == 0);
      pre   = (s == 0) ? 2'b11 : 2'b00;
      exp_w = pre;
      found = 0;
      poke(idx, pre);
      drive_trn(idx, 7'd0, tk, 1'b0);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus.mem_en && bus.mem_we) begin found = 1; break; end
      end
      n_vec++;
      if (found !== 1'b1 || bus.mem_addr !== idx || bus.mem_wdata !== exp_w) begin
        n_err++;
        $display("FAIL saturate_%0d: found=%0b addr=%h data=%b, expected addr=%h data=%b",
                 s, found, bus.mem_addr, bus.mem_wdata, idx, exp_w);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_seq [3];
    int         got = 0;
    exp_seq[0] = 2'b10; exp_seq[1] = 2'b11; exp_seq[2] = 2'b10;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      bus.trn_valid = 1'b1; bus.trn_pc = 7'd30; bus.trn_history = 7'd0;
      bus.trn_taken = (j < 2); bus.trn_mispredicted = 1'b0;
    end
    @(posedge clk); #1;
    bus.trn_valid = 1'b0;
    for (int i = 0; i < 30 && got < 3; i++) begin
      @(negedge clk);
      if (bus.mem_en && bus.mem_we) begin
        n_vec++;
        if (bus.mem_addr !== 7'd30 || bus.mem_wdata !== exp_seq[got]) begin
          n_err++;
          $display("FAIL accumulate_%0d: addr=%h data=%b, expected addr=1e data=%b",
                   got, bus.mem_addr, bus.mem_wdata, exp_seq[got]);
        end
        got++;
      end
    end
    n_vec++;
    if (got !== 3) begin n_err++; $display("FAIL accumulate_count: writes=%0d expected 3", got); end
  endtask

  task automatic test_full;
    int e = 0;
    bit seen4 = 0;
    bit seen_ret = 0;
    for (int a = 40; a < 48; a++) poke(7'(a), 2'b00);
    @(posedge clk); #1;
    bus.pred_valid = 1'b1; bus.pred_pc = 7'h11;
    for (int cyc = 0; cyc < 200 && !(e == 8 && bus.fifo_count == 3'd0 && !bus.trn_valid); cyc++) begin
      @(posedge clk); #1;
      if (e < 8) begin
        bus.trn_valid = 1'b1; bus.trn_pc = 7'(40 + e); bus.trn_history = 7'd0;
        bus.trn_taken = 1'b0; bus.trn_mispredicted = 1'b0;
      end else bus.trn_valid = 1'b0;
      @(negedge clk);
      if (bus.fifo_count == 3'd4 && !seen4) begin
        seen4 = 1;
        n_vec++;
        if ({bus.pred_ready, bus.trn_ready} !== 2'b00) begin
          n_err++;
          $display("FAIL full_ready: prdy=%0b trdy=%0b, expected 0 0", bus.pred_ready, bus.trn_ready);
        end
      end
      if (seen4 && !seen_ret && bus.fifo_count < 3'd4 && !bus.pred_resp_valid) begin
        seen_ret = 1;
        n_vec++;
        if (bus.pred_ready !== 1'b1) begin n_err++; $display("FAIL full_release: prdy=%0b expected 1", bus.pred_ready); end
      end
      if (bus.trn_valid && bus.trn_ready) e++;
    end
    n_vec++;
    if (e !== 8 || bus.fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL full_drain: pushed=%0d count=%0d, expected 8 and 0", e, bus.fifo_count);
    end
    n_vec++;
    if ({seen4, seen_ret} !== 2'b11) begin
      n_err++;
      $display("FAIL full_reach: full_seen=%0b release_seen=%0b, expected 1 1", seen4, seen_ret);
    end
    @(posedge clk); #1;
    bus.pred_valid = 1'b0; bus.trn_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mispredict;
    drive_pred(ghr_ref ^ 7'h60);
    bus.trn_valid = 1'b1; bus.trn_pc = 7'h30; bus.trn_history = 7'h15;
    bus.trn_taken = 1'b1; bus.trn_mispredicted = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.pred_resp_valid, bus.pred_taken, bus.trn_ready} !== 3'b101) begin
      n_err++;
      $display("FAIL mispred_setup: v=%0b t=%0b trdy=%0b, expected 1 0 1",
               bus.pred_resp_valid, bus.pred_taken, bus.trn_ready);
    end
    @(posedge clk); #1;
    bus.trn_valid = 1'b0; bus.trn_mispredicted = 1'b0;
    drive_pred(7'd0);
    @(negedge clk);
    n_vec++;
    if ({bus.pred_resp_valid, bus.pred_history} !== {1'b1, 7'h2B}) begin
      n_err++;
      $display("FAIL mispred_ghr: v=%0b hist=%h, expected 1 2b", bus.pred_resp_valid, bus.pred_history);
    end
    repeat (8) @(negedge clk);
    n_vec++;
    if (rq.size() != 0 || wq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: resp=%0d writes=%0d, expected 0 0", rq.size(), wq.size());
    end
  endtask

  task automatic test_reset_mid;
    mon_on = 1'b0;
    @(posedge clk); #1;
    bus.trn_valid = 1'b1; bus.trn_pc = 7'd50; bus.trn_history = 7'd0; bus.trn_taken = 1'b1;
    bus.pred_valid = 1'b1; bus.pred_pc = 7'd9;
    @(posedge clk); #1;
    bus.trn_valid = 1'b0; bus.pred_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.pred_resp_valid, bus.fifo_count} !== {1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL midreset_setup: v=%0b count=%0d, expected 1 1", bus.pred_resp_valid, bus.fifo_count);
    end
    #2 areset = 1'b1;
    #1;
    n_vec++;
    if ({bus.pred_ready, bus.trn_ready, bus.pred_resp_valid, bus.pred_taken, bus.pred_history,
         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.fifo_count} !== 24'd0) begin
      n_err++;
      $display("FAIL midreset_async: v=%0b en=%0b cnt=%0d hist=%h, expected all 0",
               bus.pred_resp_valid, bus.mem_en, bus.fifo_count, bus.pred_history);
    end
    repeat (3) @(negedge clk);
    test_init();
    drive_pred(7'd5);
    @(negedge clk);
    n_vec++;
    if ({bus.pred_resp_valid, bus.pred_taken, bus.pred_history} !== {2'b10, 7'h00}) begin
      n_err++;
      $display("FAIL midreset_pred: v=%0b t=%0b h=%h, expected 1 0 00",
               bus.pred_resp_valid, bus.pred_taken, bus.pred_history);
    end
    repeat (6) @(negedge clk);
    n_vec++;
    if (bus.fifo_count !== 3'd0 || wq.size() != 0) begin
      n_err++;
      $display("FAIL midreset_discard: count=%0d queued_writes=%0d, expected 0 0", bus.fifo_count, wq.size());
    end
  endtask

  initial begin
    bus.pred_valid = 1'b0; bus.pred_pc = 7'd0;
    bus.trn_valid = 1'b0; bus.trn_taken = 1'b0; bus.trn_mispredicted = 1'b0;
    bus.trn_history = 7'd0; bus.trn_pc = 7'd0;
    test_reset();
    test_init();
    test_predict();
    test_train();
    test_saturation();
    test_back_to_back();
    test_full();
    test_mispredict();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
